// File: rtl/seven_seg_scan_capture.sv
// Receive side of a quad seven-segment scan bus: recovers four hex digits from active-low anode/cathode lines.
// Optional build macro SEG_DP_CAPTURE_EN: include dp in the stability compare and capture it into dp_val.
module seven_seg_scan_capture #(
    parameter int unsigned SETTLE  = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] an,
    input  logic [6:0] seg,
    input  logic       dp,
    output logic [3:0] val3,
    output logic [3:0] val2,
    output logic [3:0] val1,
    output logic [3:0] val0,
    output logic [3:0] digit_valid,
    output logic [3:0] dp_val,
    output logic       frame_done,
    output logic       pattern_err,
    output logic       scan_timeout
);

    localparam int unsigned CW = $clog2(SETTLE + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
`ifdef SEG_DP_CAPTURE_EN
    localparam int unsigned SW = 12;
`else
    localparam int unsigned SW = 11;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tcnt_q;
    logic [3:0]      an_m, an_s;
    logic [6:0]      seg_m, seg_s;
    logic [SW-1:0]   sample_c, prev_q;
    logic            same_c, legal_c, capture_c;
    logic [3:0]      prev_an_c, sel_c, mask_q, mask_or_c;
    logic [6:0]      prev_seg_c;
    logic [4:0]      dec_c;
    logic [3:0]      val_q [4];

    // Two-flop synchronizers; reset to the idle (all-dark) bus level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_m  <= 4'hF;
            an_s  <= 4'hF;
            seg_m <= 7'h7F;
            seg_s <= 7'h7F;
        end else begin
            an_m  <= an;
            an_s  <= an_m;
            seg_m <= seg;
            seg_s <= seg_m;
        end
    end

`ifdef SEG_DP_CAPTURE_EN
    logic dp_m, dp_s;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_m <= 1'b1;
            dp_s <= 1'b1;
        end else begin
            dp_m <= dp;
            dp_s <= dp_m;
        end
    end
    assign sample_c = {an_s, seg_s, dp_s};
`else
    logic unused_dp;
    assign unused_dp = dp;
    assign sample_c  = {an_s, seg_s};
`endif

    assign same_c     = (sample_c == prev_q);
    assign legal_c    = an_s inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    assign prev_an_c  = prev_q[SW-1 -: 4];
    assign prev_seg_c = prev_q[SW-5 -: 7];
    assign sel_c      = ~prev_an_c;
    assign mask_or_c  = mask_q | sel_c;

    // Returns {hit, code} for an active-low abcdefg pattern
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0000100: decode = 5'h19;
            7'b0001000: decode = 5'h1A;
            7'b1100000: decode = 5'h1B;
            7'b0110001: decode = 5'h1C;
            7'b1000010: decode = 5'h1D;
            7'b0110000: decode = 5'h1E;
            7'b0111000: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    assign dec_c = decode(prev_seg_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prev_q  <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= sample_c;
        end
    end

    // Capture fires from the held sample once it has been seen SETTLE times in a row
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (legal_c) begin
                    state_d = S_SETTLE;
                    cnt_d   = CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == CW'(SETTLE)) begin
                    capture_c = 1'b1;
                    if (same_c) begin
                        state_d = S_CAPTURED;
                    end else if (legal_c) begin
                        cnt_d = CW'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (same_c) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (legal_c) begin
                    cnt_d = CW'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CAPTURED: begin
                if (!same_c) begin
                    if (legal_c) begin
                        state_d = S_SETTLE;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) val_q[i] <= '0;
            digit_valid  <= '0;
            mask_q       <= '0;
            tcnt_q       <= '0;
            frame_done   <= 1'b0;
            pattern_err  <= 1'b0;
            scan_timeout <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            pattern_err <= 1'b0;
            if (capture_c) begin
                tcnt_q <= '0;
                if (dec_c[4]) begin
                    for (int i = 0; i < 4; i++) begin
                        if (sel_c[i]) val_q[i] <= dec_c[3:0];
                    end
                    digit_valid  <= digit_valid | sel_c;
                    scan_timeout <= 1'b0;
                    if (mask_or_c == 4'hF) begin
                        frame_done <= 1'b1;
                        mask_q     <= '0;
                    end else begin
                        mask_q <= mask_or_c;
                    end
                end else begin
                    digit_valid <= digit_valid & ~sel_c;
                    pattern_err <= 1'b1;
                end
            end else if (tcnt_q != TW'(TIMEOUT)) begin
                tcnt_q <= tcnt_q + TW'(1);
                if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    scan_timeout <= 1'b1;
                    digit_valid  <= '0;
                    mask_q       <= '0;
                end
            end
        end
    end

`ifdef SEG_DP_CAPTURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_val <= '0;
        end else if (capture_c) begin
            dp_val <= (dp_val & ~sel_c) | (prev_q[0] ? 4'b0000 : sel_c);
        end
    end
`else
    assign dp_val = 4'b0000;
`endif

    assign val0 = val_q[0];
    assign val1 = val_q[1];
    assign val2 = val_q[2];
    assign val3 = val_q[3];

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Bench for seven_seg_scan_capture: run-length reference model checked every cycle, plus directed literal checks.
module tb_seven_seg_scan_capture;

    localparam int unsigned SETTLE  = 16;
    localparam int unsigned TIMEOUT = 300;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0111000;
    localparam logic [6:0] SX = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] an  = 4'hF;
    logic [6:0] seg = 7'h7F;
    logic       dp  = 1'b1;
    logic [3:0] val3, val2, val1, val0, digit_valid, dp_val;
    logic       frame_done, pattern_err, scan_timeout;

    int vectors = 0;
    int errors  = 0;
    int fd_cnt  = 0;
    int pe_cnt  = 0;

    seven_seg_scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp),
        .val3(val3), .val2(val2), .val1(val1), .val0(val0),
        .digit_valid(digit_valid), .dp_val(dp_val),
        .frame_done(frame_done), .pattern_err(pattern_err), .scan_timeout(scan_timeout)
    );

    always #5 clk = ~clk;

    // Reference model: digit recovered once per run of >= SETTLE identical legal samples
    logic [6:0]  tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    logic [3:0]  m_val [4];
    logic [3:0]  m_dv, m_mask, m_dpv;
    logic        m_fd, m_pe, m_to;
    int          m_tcnt, run;
    logic [11:0] p1, p2, last, msample;

    function automatic logic [11:0] key(input logic [11:0] s);
`ifdef SEG_DP_CAPTURE_EN
        return s;
`else
        return {s[11:1], 1'b0};
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_val[i] = 4'h0;
            m_dv = 0; m_mask = 0; m_dpv = 0; m_fd = 0; m_pe = 0; m_to = 0;
            m_tcnt = 0; run = 1;
            p1 = 12'hFFF; p2 = 12'hFFF; last = 12'hFFF;
        end else begin
            logic [3:0] a;
            int idx, code;
            msample = p2; p2 = p1; p1 = {an, seg, dp};
            m_fd = 0; m_pe = 0;
            a = last[11:8];
            if (run == SETTLE && $countones(~a) == 1) begin
                idx = 0; code = -1;
                for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
                for (int k = 0; k < 16; k++) if (tbl[k] == last[7:1]) code = k;
                m_tcnt = 0;
`ifdef SEG_DP_CAPTURE_EN
                m_dpv[idx] = ~last[0];
`endif
                if (code >= 0) begin
                    m_val[idx] = 4'(code);
                    m_dv[idx] = 1'b1;
                    m_to = 0;
                    m_mask[idx] = 1'b1;
                    if (m_mask == 4'hF) begin
                        m_fd = 1; m_mask = 0;
                    end
                end else begin
                    m_dv[idx] = 1'b0;
                    m_pe = 1;
                end
            end else if (m_tcnt < TIMEOUT) begin
                m_tcnt++;
                if (m_tcnt == TIMEOUT) begin
                    m_to = 1; m_dv = 0; m_mask = 0;
                end
            end
            if (key(msample) == key(last)) run++;
            else run = 1;
            last = msample;
        end
    end

    // Every-cycle comparison of the whole output bundle against the model
    always @(negedge clk) begin
        vectors++;
        if ({val3, val2, val1, val0, digit_valid, dp_val, frame_done, pattern_err, scan_timeout} !==
            {m_val[3], m_val[2], m_val[1], m_val[0], m_dv, m_dpv, m_fd, m_pe, m_to}) begin
            errors++;
            $display("FAIL cycle_compare t=%0t dut val=%h%h%h%h dv=%b dp=%b fd=%b pe=%b to=%b required val=%h%h%h%h dv=%b dp=%b fd=%b pe=%b to=%b",
                     $time, val3, val2, val1, val0, digit_valid, dp_val, frame_done, pattern_err, scan_timeout,
                     m_val[3], m_val[2], m_val[1], m_val[0], m_dv, m_dpv, m_fd, m_pe, m_to);
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (pattern_err === 1'b1) pe_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an = a; seg = s; dp = d;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [6:0] codes [4];
        codes = '{S3, SA, S0, SF};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_vals", {val3, val2, val1, val0}, 0);
        check("reset_flags", {digit_valid, dp_val, frame_done, pattern_err, scan_timeout}, 0);

        // Two full scans of 3,A,0,F
        for (int s = 0; s < 2; s++) begin
            for (int d = 0; d < 4; d++) begin
                drive(~(4'b0001 << d), codes[d], 1'b1, 40);
                drive(4'hF, SX, 1'b1, 4);
            end
        end
        check("scan_val0", val0, 4'h3);
        check("scan_val1", val1, 4'hA);
        check("scan_val2", val2, 4'h0);
        check("scan_val3", val3, 4'hF);
        check("scan_valid", digit_valid, 4'hF);
        check("scan_frames", fd_cnt, 2);
        check("scan_no_err", pe_cnt, 0);

        // Segments toggling faster than SETTLE never capture
        for (int k = 0; k < 5; k++) begin
            drive(4'b1110, S4, 1'b1, 8);
            drive(4'b1110, S5, 1'b1, 8);
        end
        drive(4'hF, SX, 1'b1, 4);
        check("toggle_valid", digit_valid, 4'hF);
        check("toggle_val0", val0, 4'h3);

        // Undecodable pattern on digit 1
        drive(4'b1101, SX, 1'b1, 40);
        drive(4'hF, SX, 1'b1, 4);
        check("bad_err_pulses", pe_cnt, 1);
        check("bad_valid", digit_valid, 4'b1101);
        check("bad_val1_held", val1, 4'hA);

        // Scan stops long enough to time out, then resumes
        drive(4'hF, SX, 1'b1, TIMEOUT + 10);
        check("timeout_level", scan_timeout, 1);
        check("timeout_valid", digit_valid, 0);
        check("timeout_val0_held", val0, 4'h3);
        drive(4'b1110, S5, 1'b1, 40);
        drive(4'hF, SX, 1'b1, 4);
        check("resume_timeout", scan_timeout, 0);
        check("resume_valid", digit_valid, 4'b0001);
        check("resume_val0", val0, 4'h5);

        // Digit 2 with the decimal point lit
        drive(4'b1011, S0, 1'b0, 40);
        drive(4'hF, SX, 1'b1, 4);
`ifdef SEG_DP_CAPTURE_EN
        check("dp_capture", dp_val, 4'b0100);
`else
        check("dp_capture", dp_val, 4'b0000);
`endif
        check("dp_digit_valid", digit_valid, 4'b0101);

        // Asynchronous reset in the middle of a settling digit
        drive(4'b1110, S3, 1'b1, 10);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midreset_vals", {val3, val2, val1, val0}, 0);
        check("midreset_flags", {digit_valid, dp_val, frame_done, pattern_err, scan_timeout}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b1110, S3, 1'b1, 40);
        drive(4'hF, SX, 1'b1, 4);
        check("after_reset_valid", digit_valid, 4'b0001);
        check("after_reset_val0", val0, 4'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
